// File: rtl/mem_block_mover_if.sv
// rtl/mem_block_mover_if.sv - data-memory port bundle between block mover (master) and memory (slave)
interface mem_block_mover_if #(
    parameter int ADDRESS_WIDTH = 12,
    parameter int DATA_WIDTH    = 16
);
    logic [ADDRESS_WIDTH-1:0] Address;
    logic [DATA_WIDTH-1:0]    WriteData;
    logic                     MemWrite;
    logic [DATA_WIDTH-1:0]    MemData;

    modport master (
        output Address,
        output WriteData,
        output MemWrite,
        input  MemData
    );

    modport slave (
        input  Address,
        input  WriteData,
        input  MemWrite,
        output MemData
    );
endinterface

// File: rtl/mem_block_mover.sv
// rtl/mem_block_mover.sv - block copy/fill bus master for the 16-bit data memory
// Optional write-sum accumulator on Checksum when MEM_BLOCK_MOVER_CHECKSUM_EN is defined.
module mem_block_mover #(
    parameter int ADDRESS_WIDTH = 12,
    parameter int DATA_WIDTH    = 16
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Start,
    input  logic                     Mode,
    input  logic [ADDRESS_WIDTH-1:0] SrcAddr,
    input  logic [ADDRESS_WIDTH-1:0] DstAddr,
    input  logic [ADDRESS_WIDTH:0]   Length,
    input  logic [DATA_WIDTH-1:0]    FillData,
    mem_block_mover_if.master        mem,
    output logic                     Busy,
    output logic                     Done,
    output logic [DATA_WIDTH-1:0]    Checksum
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_FILL  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [ADDRESS_WIDTH:0] COUNT_ONE = {{ADDRESS_WIDTH{1'b0}}, 1'b1};

    logic [2:0]               state;
    logic [ADDRESS_WIDTH-1:0] src_ptr;
    logic [ADDRESS_WIDTH-1:0] dst_ptr;
    logic [ADDRESS_WIDTH:0]   remaining;
    logic [DATA_WIDTH-1:0]    fill_value;
    logic [DATA_WIDTH-1:0]    hold_data;

    logic [ADDRESS_WIDTH-1:0] address_d;
    logic [DATA_WIDTH-1:0]    write_data_d;
    logic                     mem_write_d;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= S_IDLE;
            src_ptr    <= '0;
            dst_ptr    <= '0;
            remaining  <= '0;
            fill_value <= '0;
            hold_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        src_ptr    <= SrcAddr;
                        dst_ptr    <= DstAddr;
                        remaining  <= Length;
                        fill_value <= FillData;
                        if (Length == '0)
                            state <= S_DONE;
                        else if (Mode)
                            state <= S_FILL;
                        else
                            state <= S_READ;
                    end
                end
                S_READ: begin
                    hold_data <= mem.MemData;
                    src_ptr   <= src_ptr + 1'b1;
                    state     <= S_WRITE;
                end
                S_WRITE: begin
                    dst_ptr   <= dst_ptr + 1'b1;
                    remaining <= remaining - 1'b1;
                    state     <= (remaining == COUNT_ONE) ? S_DONE : S_READ;
                end
                S_FILL: begin
                    dst_ptr   <= dst_ptr + 1'b1;
                    remaining <= remaining - 1'b1;
                    state     <= (remaining == COUNT_ONE) ? S_DONE : S_FILL;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Port outputs decode straight from state so an asynchronous reset drops them at once.
    always_comb begin
        address_d    = '0;
        write_data_d = '0;
        mem_write_d  = 1'b0;
        case (state)
            S_READ: begin
                address_d = src_ptr;
            end
            S_WRITE: begin
                address_d    = dst_ptr;
                write_data_d = hold_data;
                mem_write_d  = 1'b1;
            end
            S_FILL: begin
                address_d    = dst_ptr;
                write_data_d = fill_value;
                mem_write_d  = 1'b1;
            end
            default: begin
                address_d    = '0;
                write_data_d = '0;
                mem_write_d  = 1'b0;
            end
        endcase
    end

    assign mem.Address   = address_d;
    assign mem.WriteData = write_data_d;
    assign mem.MemWrite  = mem_write_d;

    assign Busy = (state == S_READ) || (state == S_WRITE) || (state == S_FILL);
    assign Done = (state == S_DONE);

`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_acc;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            checksum_acc <= '0;
        else if ((state == S_IDLE) && Start)
            checksum_acc <= '0;
        else if (mem_write_d)
            checksum_acc <= checksum_acc + write_data_d;
    end

    assign Checksum = checksum_acc;
`else
    assign Checksum = '0;
`endif

endmodule

// File: tb/tb_mem_block_mover.sv
// tb/tb_mem_block_mover.sv - scoreboard bench for mem_block_mover copy/fill/wrap/reset behaviour
module tb_mem_block_mover;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Mode = 1'b0;
    logic [11:0] SrcAddr = '0;
    logic [11:0] DstAddr = '0;
    logic [12:0] Length = '0;
    logic [15:0] FillData = '0;
    logic        Busy;
    logic        Done;
    logic [15:0] Checksum;

    mem_block_mover_if #(.ADDRESS_WIDTH(12), .DATA_WIDTH(16)) bus ();

    mem_block_mover #(.ADDRESS_WIDTH(12), .DATA_WIDTH(16)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .Mode     (Mode),
        .SrcAddr  (SrcAddr),
        .DstAddr  (DstAddr),
        .Length   (Length),
        .FillData (FillData),
        .mem      (bus),
        .Busy     (Busy),
        .Done     (Done),
        .Checksum (Checksum)
    );

    always #5 Clk = ~Clk;

    logic [15:0] mem [0:4095];
    logic        tb_we = 1'b0;
    logic [11:0] tb_addr = '0;
    logic [15:0] tb_data = '0;

    assign bus.MemData = mem[bus.Address];

    always @(posedge Clk) begin
        if (bus.MemWrite)
            mem[bus.Address] <= bus.WriteData;
        else if (tb_we)
            mem[tb_addr] <= tb_data;
    end

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_done;
        logic [11:0] addr;
        logic [15:0] data;
        int          at;
    } ev_t;

    ev_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;

    ev_t mon_e;
    bit  mon_ok;

    always @(negedge Clk) begin
        if (!Reset && (bus.MemWrite || Done)) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event: cyc=%0d MemWrite=%b Done=%b Address=%h WriteData=%h, expected no event",
                         cyc, bus.MemWrite, Done, bus.Address, bus.WriteData);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.is_done)
                    mon_ok = Done && !bus.MemWrite && (Checksum == mon_e.data) && (cyc == mon_e.at);
                else
                    mon_ok = bus.MemWrite && !Done && (bus.Address == mon_e.addr) &&
                             (bus.WriteData == mon_e.data) && (cyc == mon_e.at);
                if (!mon_ok) begin
                    miscompares++;
                    $display("FAIL %s_event: got cyc=%0d MemWrite=%b Done=%b Address=%h WriteData=%h Checksum=%h, expected cyc=%0d addr=%h data=%h",
                             mon_e.is_done ? "done" : "write", cyc, bus.MemWrite, Done, bus.Address,
                             bus.WriteData, Checksum, mon_e.at, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    function automatic logic [15:0] cs(input logic [15:0] v);
`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
        return v;
`else
        return 16'h0000 & v;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic poke(input logic [11:0] a, input logic [15:0] d);
        tb_we   = 1'b1;
        tb_addr = a;
        tb_data = d;
        tick();
        tb_we   = 1'b0;
    endtask

    // Returns the cycle counter value seen during cycle 1 of the accepted operation.
    task automatic start_op(input logic m, input logic [11:0] s, input logic [11:0] d,
                            input logic [12:0] l, input logic [15:0] f, output int c0);
        Mode     = m;
        SrcAddr  = s;
        DstAddr  = d;
        Length   = l;
        FillData = f;
        Start    = 1'b1;
        tick();
        c0       = cyc;
        Start    = 1'b0;
        Mode     = ~m;
        SrcAddr  = 12'hABC;
        DstAddr  = 12'h321;
        Length   = 13'd7;
        FillData = 16'hFFFF;
    endtask

    task automatic push_w(input logic [11:0] a, input logic [15:0] d, input int c0, input int n);
        exp_q.push_back('{1'b0, a, d, c0 + n - 1});
    endtask

    task automatic push_d(input logic [15:0] sum, input int c0, input int n);
        exp_q.push_back('{1'b1, 12'h000, sum, c0 + n - 1});
    endtask

    int c0;

    initial begin
        repeat (2) tick();
        check("reset_address",   {20'h0, bus.Address}, 32'h0);
        check("reset_writedata", {16'h0, bus.WriteData}, 32'h0);
        check("reset_memwrite",  {31'h0, bus.MemWrite}, 32'h0);
        check("reset_busy",      {31'h0, Busy}, 32'h0);
        check("reset_done",      {31'h0, Done}, 32'h0);
        check("reset_checksum",  {16'h0, Checksum}, 32'h0);
        Reset = 1'b0;
        tick();

        // Copy 3 words 10 -> 40
        poke(12'd10, 16'h1111);
        poke(12'd11, 16'h2222);
        poke(12'd12, 16'h3333);
        start_op(1'b0, 12'd10, 12'd40, 13'd3, 16'h0, c0);
        push_w(12'd40, 16'h1111, c0, 2);
        push_w(12'd41, 16'h2222, c0, 4);
        push_w(12'd42, 16'h3333, c0, 6);
        push_d(cs(16'h6666), c0, 7);
        repeat (8) tick();
        check("copy_mem40", {16'h0, mem[40]}, 32'h1111);
        check("copy_mem41", {16'h0, mem[41]}, 32'h2222);
        check("copy_mem42", {16'h0, mem[42]}, 32'h3333);

        // Fill 4 words at 100
        start_op(1'b1, 12'd0, 12'd100, 13'd4, 16'hBEEF, c0);
        push_w(12'd100, 16'hBEEF, c0, 1);
        push_w(12'd101, 16'hBEEF, c0, 2);
        push_w(12'd102, 16'hBEEF, c0, 3);
        push_w(12'd103, 16'hBEEF, c0, 4);
        push_d(cs(16'hFBBC), c0, 5);
        for (int n = 1; n <= 5; n++) begin
            @(negedge Clk);
            check($sformatf("fill_busy_cycle%0d", n), {31'h0, Busy}, (n <= 4) ? 32'h1 : 32'h0);
        end
        repeat (2) tick();
        check("fill_mem100", {16'h0, mem[100]}, 32'hBEEF);
        check("fill_mem103", {16'h0, mem[103]}, 32'hBEEF);

        // Fill wrapping past the top of memory
        poke(12'd1, 16'h1234);
        start_op(1'b1, 12'd0, 12'd4094, 13'd3, 16'h00A5, c0);
        push_w(12'd4094, 16'h00A5, c0, 1);
        push_w(12'd4095, 16'h00A5, c0, 2);
        push_w(12'd0,    16'h00A5, c0, 3);
        push_d(cs(16'h01EF), c0, 4);
        repeat (5) tick();
        check("wrap_mem4094", {16'h0, mem[4094]}, 32'h00A5);
        check("wrap_mem4095", {16'h0, mem[4095]}, 32'h00A5);
        check("wrap_mem0",    {16'h0, mem[0]},    32'h00A5);
        check("wrap_mem1",    {16'h0, mem[1]},    32'h1234);

        // Zero length: Done in cycle 1, no write
        start_op(1'b0, 12'd10, 12'd900, 13'd0, 16'h0, c0);
        push_d(cs(16'h0000), c0, 1);
        repeat (3) tick();

        // Start pulsed mid-copy is ignored
        poke(12'd200, 16'h0A01);
        poke(12'd201, 16'h0A02);
        poke(12'd202, 16'h0A03);
        poke(12'd203, 16'h0A04);
        poke(12'd204, 16'h0A05);
        poke(12'd700, 16'h7777);
        start_op(1'b0, 12'd200, 12'd300, 13'd5, 16'h0, c0);
        for (int k = 0; k < 5; k++)
            push_w(12'd300 + 12'(k), 16'h0A01 + 16'(k), c0, 2 * k + 2);
        push_d(cs(16'h320F), c0, 11);
        repeat (2) tick();
        Mode     = 1'b1;
        DstAddr  = 12'd700;
        Length   = 13'd2;
        FillData = 16'h5555;
        Start    = 1'b1;
        tick();
        Start    = 1'b0;
        repeat (9) tick();
        check("busy_start_mem304", {16'h0, mem[304]}, 32'h0A05);
        check("busy_start_mem700", {16'h0, mem[700]}, 32'h7777);

        // Reset asserted in cycle 5 of an 8-word copy
        for (int i = 0; i < 8; i++) begin
            poke(12'(i), 16'h5000 + 16'(i));
            poke(12'd64 + 12'(i), 16'hDEAD);
        end
        start_op(1'b0, 12'd0, 12'd64, 13'd8, 16'h0, c0);
        push_w(12'd64, 16'h5000, c0, 2);
        push_w(12'd65, 16'h5001, c0, 4);
        repeat (4) tick();
        Reset = 1'b1;
        #1;
        check("midreset_address",   {20'h0, bus.Address}, 32'h0);
        check("midreset_memwrite",  {31'h0, bus.MemWrite}, 32'h0);
        check("midreset_busy",      {31'h0, Busy}, 32'h0);
        check("midreset_done",      {31'h0, Done}, 32'h0);
        check("midreset_checksum",  {16'h0, Checksum}, 32'h0);
        repeat (2) tick();
        Reset = 1'b0;
        tick();
        check("midreset_mem64", {16'h0, mem[64]}, 32'h5000);
        check("midreset_mem65", {16'h0, mem[65]}, 32'h5001);
        check("midreset_mem66", {16'h0, mem[66]}, 32'hDEAD);
        check("midreset_mem71", {16'h0, mem[71]}, 32'hDEAD);

        // Normal operation after reset
        start_op(1'b0, 12'd10, 12'd500, 13'd2, 16'h0, c0);
        push_w(12'd500, 16'h1111, c0, 2);
        push_w(12'd501, 16'h2222, c0, 4);
        push_d(cs(16'h3333), c0, 5);
        repeat (6) tick();
        check("post_reset_mem501", {16'h0, mem[501]}, 32'h2222);

        check("scoreboard_drained", exp_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
